ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Sits between the ps2_keyboard FIFO and the display and segment logic in the top level.
- Pops raw PS/2 Set-2 bytes from the FIFO and resolves E0 (extended) and F0 (break) prefixes.
- Tracks the shift keys and suppresses typematic repeats of the key currently held.
- Emits one clean single-cycle key event per new press, carrying the scan code, ASCII and a running press count. Glyph lookup and the count display consume these outputs directly.

Parameters:
- CNT_W, 8, width of press counter press_cnt.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- kbd_data  in  8  FIFO head byte from ps2_keyboard.
- kbd_ready  in  1  FIFO non-empty.
- kbd_overflow  in  1  FIFO overflow flag.
- kbd_nextdata_n  out  1  active-low pop; registered.
- key_valid  out  1  one-cycle pulse per accepted make event.
- key_code  out  8  scan code of the last accepted make (without prefix).
- key_ext  out  1  last accepted make was E0-prefixed.
- key_ascii  out  8  ASCII of the last accepted make; 0x00 if unmapped.
- key_held  out  1  level: last accepted key is still down.
- shift  out  1  level: left (12h) or right (59h) shift is down.
- press_cnt  out  CNT_W  count of accepted make events.
- err  out  1  sticky overflow indicator.

Behaviour:
- Reset values: kbd_nextdata_n=1. All other outputs 0. Internal brk_pend, ext_pend, held_code and state=IDLE all cleared. Reset asserted mid-pop aborts the pop; the FIFO byte is re-read after reset.
- FSM has 2 states.
  - IDLE: if kbd_ready=1, latch kbd_data into byte_r, set kbd_nextdata_n<=0, go to POP. Otherwise stay; nextdata_n stays 1.
  - POP: set kbd_nextdata_n<=1, decode byte_r, go to IDLE.
- kbd_nextdata_n is low for exactly 1 cycle per byte. Maximum throughput is 1 byte per 2 cycles.
- Latency: ready sampled at edge N → nextdata_n low during cycle N+1 → key_valid high during cycle N+2 only.
- Decode in POP, priority order:
  1. byte E0h → ext_pend<=1. No event.
  2. byte F0h → brk_pend<=1. No event.
  3. Any other byte with brk_pend=1 (release):
     - Shift release (12h/59h, ext_pend=0) clears the shift flag.
     - If byte==held_code and ext_pend==key_ext, key_held<=0.
     - No key_valid.
     - Clear both pend flags.
  4. Any other byte with brk_pend=0 (make):
     - Shift make (ext_pend=0): shift<=1, no key_valid.
     - Typematic: key_held=1 and byte==key_code and ext_pend==key_ext → suppressed, no outputs change.
     - Otherwise: key_valid<=1, key_code<=byte, key_ext<=ext_pend, key_ascii<=lookup, key_held<=1, press_cnt<=press_cnt+1.
     - Clear both pend flags.
- press_cnt wraps from all-ones to 0 with no saturation.
- key_valid deasserts the cycle after it pulses.
- ASCII lookup uses the standard Set-2 map, non-extended only; extended makes give 0x00.
  - Letters: lowercase, uppercase when shift=1 at decode. Examples: 15h→'q'/0x71, 23h→'d'/0x64, 1Ch→'a', 1Ah→'z'.
  - Digits: 45h,16h,1Eh,26h,25h,2Eh,36h,3Dh,3Eh,46h → '0'..'9'. Shift does not affect digits.
  - 29h→0x20, 5Ah→0x0D.
  - All other codes → 0x00.
- Only one tracked held key. A make of a different key replaces key_code and is accepted even if the previous key is still down.
- Releasing a non-held key never changes key_held.
- err <= err | kbd_overflow each cycle. Only rst clears it.
- Prefix bytes F0/E0 arriving back-to-back: both flags accumulate. E0 F0 xx and F0 E0 xx are treated identically.

Test Plan:
- After reset, push 15h → nextdata_n low exactly 1 cycle. key_valid pulses 2 cycles after ready, with key_code=15h, key_ascii=0x71, key_held=1, press_cnt=1.
- Push 15h,15h,15h (typematic), then F0,15h → one key_valid total, press_cnt=1, key_held=0 after the 15h following F0.
- Push 12h, 23h, F0,12h, 23h → first event ascii=0x44 ('D'), shift=1. After the shift release shift=0. The second 23h is suppressed while key_held=1 (no F0 23 was sent).
- Push E0,75h → key_valid, key_ext=1, key_code=75h, key_ascii=0x00. Then push 75h (non-ext) → accepted as a new key, key_ext=0.
- Preload press_cnt via 255 distinct press/release pairs, then one more make → press_cnt=0. Pulse kbd_overflow for 1 cycle → err=1 until rst.
- Assert rst on the cycle nextdata_n is low → after reset nextdata_n=1, all outputs 0, and the byte still in the FIFO is decoded normally.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 byte decoder: pops bytes from the keyboard FIFO and resolves E0/F0 prefixes.
// It tracks the shift keys and emits one clean event, with ASCII and a press count, per new key press.
module ps2_key_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  input  logic             kbd_overflow,
  output logic             kbd_nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [7:0]       key_ascii,
  output logic             key_held,
  output logic             shift,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err,
  output logic             dbg_state
);

  // FIFO handshake: a byte is taken when kbd_ready=1 is seen in IDLE. kbd_nextdata_n is then
  // held low for exactly the following cycle, which is the FIFO's pop strobe.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_POP  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic             brk_pend_q, brk_pend_d;
  logic             ext_pend_q, ext_pend_d;
  logic             key_valid_q, key_valid_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_ext_q, key_ext_d;
  logic [7:0]       key_ascii_q, key_ascii_d;
  logic             key_held_q, key_held_d;
  logic             shift_q, shift_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             err_q, err_d;

  logic is_shift_code;
  logic is_repeat;

  function automatic logic [7:0] set2_ascii(input logic [7:0] code, input logic upper);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20; 8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    // Only letters have an upper-case form; digits ignore shift.
    if (upper && (a >= 8'h61) && (a <= 8'h7A)) a = a - 8'h20;
    return a;
  endfunction

  assign is_shift_code = ((byte_q == 8'h12) || (byte_q == 8'h59)) && !ext_pend_q;
  assign is_repeat     = key_held_q && (byte_q == key_code_q) && (ext_pend_q == key_ext_q);

  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    nextdata_n_d = 1'b1;
    brk_pend_d   = brk_pend_q;
    ext_pend_d   = ext_pend_q;
    key_valid_d  = 1'b0;
    key_code_d   = key_code_q;
    key_ext_d    = key_ext_q;
    key_ascii_d  = key_ascii_q;
    key_held_d   = key_held_q;
    shift_d      = shift_q;
    press_cnt_d  = press_cnt_q;
    err_d        = err_q | kbd_overflow;

    case (state_q)
      ST_IDLE: begin
        if (kbd_ready) begin
          byte_d       = kbd_data;
          nextdata_n_d = 1'b0;
          state_d      = ST_POP;
        end
      end
      ST_POP: begin
        state_d = ST_IDLE;
        if (byte_q == 8'hE0) begin
          ext_pend_d = 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_pend_d = 1'b1;
        end else if (brk_pend_q) begin
          // Release: a non-held key never disturbs key_held.
          if (is_shift_code) shift_d = 1'b0;
          if ((byte_q == key_code_q) && (ext_pend_q == key_ext_q)) key_held_d = 1'b0;
          brk_pend_d = 1'b0;
          ext_pend_d = 1'b0;
        end else begin
          if (is_shift_code) begin
            shift_d = 1'b1;
          end else if (!is_repeat) begin
            key_valid_d = 1'b1;
            key_code_d  = byte_q;
            key_ext_d   = ext_pend_q;
            key_ascii_d = ext_pend_q ? 8'h00 : set2_ascii(byte_q, shift_q);
            key_held_d  = 1'b1;
            press_cnt_d = press_cnt_q + CNT_W'(1);
          end
          brk_pend_d = 1'b0;
          ext_pend_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      byte_q       <= 8'h00;
      nextdata_n_q <= 1'b1;
      brk_pend_q   <= 1'b0;
      ext_pend_q   <= 1'b0;
      key_valid_q  <= 1'b0;
      key_code_q   <= 8'h00;
      key_ext_q    <= 1'b0;
      key_ascii_q  <= 8'h00;
      key_held_q   <= 1'b0;
      shift_q      <= 1'b0;
      press_cnt_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      nextdata_n_q <= nextdata_n_d;
      brk_pend_q   <= brk_pend_d;
      ext_pend_q   <= ext_pend_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_ascii_q  <= key_ascii_d;
      key_held_q   <= key_held_d;
      shift_q      <= shift_d;
      press_cnt_q  <= press_cnt_d;
      err_q        <= err_d;
    end
  end

  assign kbd_nextdata_n = nextdata_n_q;
  assign key_valid      = key_valid_q;
  assign key_code       = key_code_q;
  assign key_ext        = key_ext_q;
  assign key_ascii      = key_ascii_q;
  assign key_held       = key_held_q;
  assign shift          = shift_q;
  assign press_cnt      = press_cnt_q;
  assign err            = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: table of bytes with hand-computed results,
// plus hand-written sequences for counter wrap, overflow and reset during a pop.
module tb_ps2_key_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_overflow;
  logic       kbd_nextdata_n;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic [7:0] key_ascii;
  logic       key_held;
  logic       shift;
  logic [7:0] press_cnt;
  logic       err;
  logic       dbg_state;

  int total;
  int bad;

  typedef struct {
    logic [7:0] b;
    logic       v;
    logic [7:0] code;
    logic       ext;
    logic [7:0] ascii;
    logic       held;
    logic       sh;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  ps2_key_decoder #(.CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .kbd_overflow   (kbd_overflow),
    .kbd_nextdata_n (kbd_nextdata_n),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .key_ext        (key_ext),
    .key_ascii      (key_ascii),
    .key_held       (key_held),
    .shift          (shift),
    .press_cnt      (press_cnt),
    .err            (err),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [7:0] b, input logic v, input logic [7:0] code,
                         input logic ext, input logic [7:0] ascii, input logic held,
                         input logic sh, input logic [7:0] cnt);
    vec_t t;
    t.b = b; t.v = v; t.code = code; t.ext = ext;
    t.ascii = ascii; t.held = held; t.sh = sh; t.cnt = cnt;
    vecs.push_back(t);
  endtask

  // Offer one byte as the FIFO head; check the pop strobe timing and return
  // whether key_valid pulsed two cycles after ready was sampled.
  task automatic send_byte(input logic [7:0] b, output logic pulsed);
    @(negedge clk);
    kbd_data  = b;
    kbd_ready = 1'b1;
    @(negedge clk);
    chk("pop_low", {31'd0, kbd_nextdata_n}, 32'd0);
    kbd_ready = 1'b0;
    @(negedge clk);
    chk("pop_high", {31'd0, kbd_nextdata_n}, 32'd1);
    pulsed = key_valid;
    @(negedge clk);
    chk("valid_drop", {31'd0, key_valid}, 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_nextdata_n"}, {31'd0, kbd_nextdata_n}, 32'd1);
    chk({tag, "_valid"}, {31'd0, key_valid}, 32'd0);
    chk({tag, "_code"}, {24'd0, key_code}, 32'd0);
    chk({tag, "_ext"}, {31'd0, key_ext}, 32'd0);
    chk({tag, "_ascii"}, {24'd0, key_ascii}, 32'd0);
    chk({tag, "_held"}, {31'd0, key_held}, 32'd0);
    chk({tag, "_shift"}, {31'd0, shift}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, press_cnt}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    logic       p;
    logic [7:0] c;
    logic [7:0] exp_cnt;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    kbd_data = 8'h00;
    kbd_ready = 1'b0;
    kbd_overflow = 1'b0;

    // b     v  code   e  ascii  h  sh cnt
    add_vec(8'h15, 1, 8'h15, 0, 8'h71, 1, 0, 8'd1);
    add_vec(8'h15, 0, 8'h15, 0, 8'h71, 1, 0, 8'd1);
    add_vec(8'h15, 0, 8'h15, 0, 8'h71, 1, 0, 8'd1);
    add_vec(8'hF0, 0, 8'h15, 0, 8'h71, 1, 0, 8'd1);
    add_vec(8'h15, 0, 8'h15, 0, 8'h71, 0, 0, 8'd1);
    add_vec(8'h12, 0, 8'h15, 0, 8'h71, 0, 1, 8'd1);
    add_vec(8'h23, 1, 8'h23, 0, 8'h44, 1, 1, 8'd2);
    add_vec(8'hF0, 0, 8'h23, 0, 8'h44, 1, 1, 8'd2);
    add_vec(8'h12, 0, 8'h23, 0, 8'h44, 1, 0, 8'd2);
    add_vec(8'h23, 0, 8'h23, 0, 8'h44, 1, 0, 8'd2);
    add_vec(8'hE0, 0, 8'h23, 0, 8'h44, 1, 0, 8'd2);
    add_vec(8'h75, 1, 8'h75, 1, 8'h00, 1, 0, 8'd3);
    add_vec(8'h75, 1, 8'h75, 0, 8'h00, 1, 0, 8'd4);
    add_vec(8'hF0, 0, 8'h75, 0, 8'h00, 1, 0, 8'd4);
    add_vec(8'h1C, 0, 8'h75, 0, 8'h00, 1, 0, 8'd4);
    add_vec(8'hE0, 0, 8'h75, 0, 8'h00, 1, 0, 8'd4);
    add_vec(8'hF0, 0, 8'h75, 0, 8'h00, 1, 0, 8'd4);
    add_vec(8'h75, 0, 8'h75, 0, 8'h00, 1, 0, 8'd4);
    add_vec(8'hF0, 0, 8'h75, 0, 8'h00, 1, 0, 8'd4);
    add_vec(8'h75, 0, 8'h75, 0, 8'h00, 0, 0, 8'd4);
    add_vec(8'h75, 1, 8'h75, 0, 8'h00, 1, 0, 8'd5);
    add_vec(8'h59, 0, 8'h75, 0, 8'h00, 1, 1, 8'd5);
    add_vec(8'h16, 1, 8'h16, 0, 8'h31, 1, 1, 8'd6);
    add_vec(8'hF0, 0, 8'h16, 0, 8'h31, 1, 1, 8'd6);
    add_vec(8'h59, 0, 8'h16, 0, 8'h31, 1, 0, 8'd6);
    add_vec(8'h29, 1, 8'h29, 0, 8'h20, 1, 0, 8'd7);
    add_vec(8'h5A, 1, 8'h5A, 0, 8'h0D, 1, 0, 8'd8);
    add_vec(8'h1A, 1, 8'h1A, 0, 8'h7A, 1, 0, 8'd9);
    add_vec(8'h45, 1, 8'h45, 0, 8'h30, 1, 0, 8'd10);
    add_vec(8'hE0, 0, 8'h45, 0, 8'h30, 1, 0, 8'd10);
    add_vec(8'h1C, 1, 8'h1C, 1, 8'h00, 1, 0, 8'd11);
    add_vec(8'hF0, 0, 8'h1C, 1, 8'h00, 1, 0, 8'd11);
    add_vec(8'hE0, 0, 8'h1C, 1, 8'h00, 1, 0, 8'd11);
    add_vec(8'h1C, 0, 8'h1C, 1, 8'h00, 0, 0, 8'd11);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      send_byte(vecs[i].b, p);
      chk($sformatf("v%0d_valid", i), {31'd0, p}, {31'd0, vecs[i].v});
      chk($sformatf("v%0d_code", i), {24'd0, key_code}, {24'd0, vecs[i].code});
      chk($sformatf("v%0d_ext", i), {31'd0, key_ext}, {31'd0, vecs[i].ext});
      chk($sformatf("v%0d_ascii", i), {24'd0, key_ascii}, {24'd0, vecs[i].ascii});
      chk($sformatf("v%0d_held", i), {31'd0, key_held}, {31'd0, vecs[i].held});
      chk($sformatf("v%0d_shift", i), {31'd0, shift}, {31'd0, vecs[i].sh});
      chk($sformatf("v%0d_cnt", i), {24'd0, press_cnt}, {24'd0, vecs[i].cnt});
    end

    // Run the counter up to all-ones with alternating press/release pairs.
    exp_cnt = 8'd11;
    for (int i = 0; i < 244; i++) begin
      c = i[0] ? 8'h1C : 8'h32;
      exp_cnt = exp_cnt + 8'd1;
      send_byte(c, p);
      chk("fill_valid", {31'd0, p}, 32'd1);
      chk("fill_cnt", {24'd0, press_cnt}, {24'd0, exp_cnt});
      chk("fill_ascii", {24'd0, key_ascii}, i[0] ? 32'h61 : 32'h62);
      send_byte(8'hF0, p);
      send_byte(c, p);
      chk("fill_release", {31'd0, key_held}, 32'd0);
    end
    chk("cnt_full", {24'd0, press_cnt}, 32'd255);
    send_byte(8'h21, p);
    chk("wrap_valid", {31'd0, p}, 32'd1);
    chk("wrap_cnt", {24'd0, press_cnt}, 32'd0);
    chk("wrap_ascii", {24'd0, key_ascii}, 32'h63);

    // Sticky overflow.
    chk("err_before", {31'd0, err}, 32'd0);
    @(negedge clk);
    kbd_overflow = 1'b1;
    @(negedge clk);
    kbd_overflow = 1'b0;
    chk("err_set", {31'd0, err}, 32'd1);
    repeat (5) @(negedge clk);
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Reset on the pop cycle: the byte stays at the FIFO head and is re-read.
    @(negedge clk);
    kbd_data  = 8'h1C;
    kbd_ready = 1'b1;
    @(negedge clk);
    chk("mid_pop_low", {31'd0, kbd_nextdata_n}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    chk("reread_pop_low", {31'd0, kbd_nextdata_n}, 32'd0);
    kbd_ready = 1'b0;
    @(negedge clk);
    chk("reread_valid", {31'd0, key_valid}, 32'd1);
    chk("reread_code", {24'd0, key_code}, 32'h1C);
    chk("reread_ascii", {24'd0, key_ascii}, 32'h61);
    chk("reread_cnt", {24'd0, press_cnt}, 32'd1);
    chk("reread_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk("reread_valid_drop", {31'd0, key_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
